// File: rtl/meter_pkg.sv
// Shared types and helpers for the audio level meter display path.
// Both this block and the display driver take their level width from level_width().
package meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AMP    = 2'd1,
    ST_LOG    = 2'd2,
    ST_UPDATE = 2'd3
  } meter_state_e;

  function automatic int level_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Section counters hold values 0..n-1; a 1-bit counter still works when n == 1.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/meter_peak_hold_if.sv
// Section min/max stream between the section min/max stage (master) and the
// display-side consumer (slave).
//
// A pair transfers on a rising clk edge where i_valid && i_ready. The master keeps
// i_min_value/i_max_value stable while i_valid is high and i_ready is low. The slave
// raises i_ready independently of i_valid.
interface meter_peak_hold_if #(
  parameter int width = 16
) ();

  logic             i_valid;
  logic             i_ready;
  logic [width-1:0] i_min_value;
  logic [width-1:0] i_max_value;

  modport master (
    output i_valid,
    output i_min_value,
    output i_max_value,
    input  i_ready
  );

  modport slave (
    input  i_valid,
    input  i_min_value,
    input  i_max_value,
    output i_ready
  );

endinterface

// File: rtl/leading_one_level.sv
// Combinational priority encoder: level = index of the highest set bit + 1, or 0 for
// a zero amplitude. Each level step is one bit, which is 6 dB.
module leading_one_level
  import meter_pkg::*;
#(
  parameter  int width = 16,
  localparam int lw    = level_width(width)
) (
  input  logic [width-1:0] amp_i,
  output logic [lw-1:0]    level_o
);

  // The scan runs upward, so the highest set bit writes level_o last.
  always_comb begin
    level_o = '0;
    for (int i = 0; i < width; i++) begin
      if (amp_i[i]) begin
        level_o = lw'(i + 1);
      end
    end
  end

endmodule

// File: rtl/meter_peak_hold.sv
// Display-side consumer of the section min/max stream. Each pair is turned into a
// logarithmic bar level with a falling-bar decay and a peak-hold marker.
module meter_peak_hold
  import meter_pkg::*;
#(
  parameter  int width          = 16,
  parameter  int hold_sections  = 32,
  parameter  int decay_sections = 4,
  localparam int lw             = level_width(width)
) (
  input  logic                  clk,
  input  logic                  reset,
  meter_peak_hold_if.slave      sec,
  output logic [lw-1:0]         o_level,
  output logic [lw-1:0]         o_peak,
  output logic                  o_update,
  output meter_state_e          o_state
);

  localparam int dcw = counter_width(decay_sections);
  localparam int hcw = counter_width(hold_sections);

  localparam logic [dcw-1:0] decay_last = dcw'(decay_sections - 1);
  localparam logic [hcw-1:0] hold_last  = hcw'(hold_sections - 1);

  meter_state_e      state_q, state_d;
  logic [width-1:0]  min_q, min_d;
  logic [width-1:0]  max_q, max_d;
  logic [width-1:0]  amp_q, amp_d;
  logic [lw-1:0]     new_level_q, new_level_d;
  logic [lw-1:0]     level_q, level_d;
  logic [lw-1:0]     peak_q, peak_d;
  logic [dcw-1:0]    decay_cnt_q, decay_cnt_d;
  logic [hcw-1:0]    hold_cnt_q, hold_cnt_d;
  logic [lw-1:0]     enc_level;
  logic [lw-1:0]     bar_next;

  leading_one_level #(
    .width (width)
  ) u_leading_one_level (
    .amp_i   (amp_q),
    .level_o (enc_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      min_q       <= '0;
      max_q       <= '0;
      amp_q       <= '0;
      new_level_q <= '0;
      level_q     <= '0;
      peak_q      <= '0;
      decay_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      max_q       <= max_d;
      amp_q       <= amp_d;
      new_level_q <= new_level_d;
      level_q     <= level_d;
      peak_q      <= peak_d;
      decay_cnt_q <= decay_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    max_d       = max_q;
    amp_d       = amp_q;
    new_level_d = new_level_q;
    level_d     = level_q;
    peak_d      = peak_q;
    decay_cnt_d = decay_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    bar_next    = level_q;

    case (state_q)
      ST_IDLE: begin
        if (sec.i_valid) begin
          min_d   = sec.i_min_value;
          max_d   = sec.i_max_value;
          state_d = ST_AMP;
        end
      end

      ST_AMP: begin
        // An inverted pair reads as silence rather than wrapping to a huge amplitude.
        amp_d   = (min_q > max_q) ? '0 : (max_q - min_q);
        state_d = ST_LOG;
      end

      ST_LOG: begin
        new_level_d = enc_level;
        state_d     = ST_UPDATE;
      end

      ST_UPDATE: begin
        if (new_level_q >= level_q) begin
          bar_next    = new_level_q;
          decay_cnt_d = '0;
        end else if (decay_cnt_q == decay_last) begin
          bar_next = level_q - lw'(1);
          if (bar_next < new_level_q) begin
            bar_next = new_level_q;
          end
          decay_cnt_d = '0;
        end else begin
          decay_cnt_d = decay_cnt_q + dcw'(1);
        end
        level_d = bar_next;

        // The marker follows the post-update bar, so it can never sit below the bar.
        if (bar_next >= peak_q) begin
          peak_d     = bar_next;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == hold_last) begin
          peak_d     = bar_next;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + hcw'(1);
        end

        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sec.i_ready = (state_q == ST_IDLE);
  assign o_update    = (state_q == ST_UPDATE);
  assign o_level     = level_q;
  assign o_peak      = peak_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_meter_peak_hold.sv
// Directed bench for meter_peak_hold with width=16, hold_sections=4, decay_sections=2.
module tb_meter_peak_hold;
  import meter_pkg::*;

  logic         clk;
  logic         reset;
  logic [4:0]   o_level;
  logic [4:0]   o_peak;
  logic         o_update;
  meter_state_e o_state;
  int           checks;
  int           errors;

  meter_peak_hold_if #(.width(16)) sec ();

  meter_peak_hold #(
    .width          (16),
    .hold_sections  (4),
    .decay_sections (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sec      (sec),
    .o_level  (o_level),
    .o_peak   (o_peak),
    .o_update (o_update),
    .o_state  (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge with i_ready expected high; returns at the negedge after T+3.
  task automatic send_pair(input logic [15:0] mn, input logic [15:0] mx,
                           input logic [4:0] exp_level, input logic [4:0] exp_peak,
                           input string name);
    int   upd_cnt;
    logic exp_ready;
    logic exp_upd;
    upd_cnt = 0;
    checks++;
    if (sec.i_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b expected 1", name, sec.i_ready);
    end
    sec.i_valid     = 1'b1;
    sec.i_min_value = mn;
    sec.i_max_value = mx;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        sec.i_valid     = 1'b0;
        sec.i_min_value = 16'h0000;
        sec.i_max_value = 16'hFFFF;
      end
      exp_ready = (k == 4);
      exp_upd   = (k == 3);
      checks++;
      if (sec.i_ready !== exp_ready) begin
        errors++;
        $display("FAIL %s ready cyc%0d: got %b expected %b", name, k, sec.i_ready, exp_ready);
      end
      checks++;
      if (o_update !== exp_upd) begin
        errors++;
        $display("FAIL %s update cyc%0d: got %b expected %b", name, k, o_update, exp_upd);
      end
      if (o_update === 1'b1) upd_cnt++;
    end
    checks++;
    if (upd_cnt != 1) begin
      errors++;
      $display("FAIL %s update_count: got %0d expected 1", name, upd_cnt);
    end
    checks++;
    if (o_level !== exp_level) begin
      errors++;
      $display("FAIL %s level: got %0d expected %0d", name, o_level, exp_level);
    end
    checks++;
    if (o_peak !== exp_peak) begin
      errors++;
      $display("FAIL %s peak: got %0d expected %0d", name, o_peak, exp_peak);
    end
    checks++;
    if (!(o_peak >= o_level)) begin
      errors++;
      $display("FAIL %s peak_ge_level: got peak %0d level %0d", name, o_peak, o_level);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    sec.i_valid     = 1'b0;
    sec.i_min_value = '0;
    sec.i_max_value = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_level !== 5'd0 || o_peak !== 5'd0 || o_update !== 1'b0 || sec.i_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_during: got lvl %0d pk %0d upd %b rdy %b expected 0 0 0 1",
               o_level, o_peak, o_update, sec.i_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_level !== 5'd0 || o_peak !== 5'd0 || o_update !== 1'b0 || sec.i_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: got lvl %0d pk %0d upd %b rdy %b expected 0 0 0 1",
               o_level, o_peak, o_update, sec.i_ready);
    end
    checks++;
    if (o_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", o_state, ST_IDLE);
    end
  endtask

  task automatic test_inverted();
    // 0x1000 - 0x9000 would wrap to 0x8000 (level 16); the block must report 0.
    send_pair(16'h9000, 16'h1000, 5'd0, 5'd0, "inverted");
  endtask

  task automatic test_level_mapping();
    send_pair(16'h8000, 16'h8000, 5'd0,  5'd0,  "map_amp0");
    send_pair(16'h8000, 16'h8001, 5'd1,  5'd1,  "map_amp1");
    send_pair(16'h7F80, 16'h8080, 5'd9,  5'd9,  "map_amp100");
    send_pair(16'h0000, 16'hFFFF, 5'd16, 5'd16, "map_ampffff");
  endtask

  task automatic test_decay_peak();
    logic [4:0] exp_lv [6];
    logic [4:0] exp_pk [6];
    exp_lv = '{5'd16, 5'd15, 5'd15, 5'd14, 5'd14, 5'd13};
    exp_pk = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd14, 5'd14};
    send_pair(16'h0000, 16'hFFFF, 5'd16, 5'd16, "decay_top");
    for (int i = 0; i < 6; i++) begin
      send_pair(16'h8000, 16'h8000, exp_lv[i], exp_pk[i], $sformatf("decay_%0d", i));
    end
  endtask

  task automatic test_handshake();
    logic [15:0] acc_amp [3];
    logic [4:0]  acc_lv  [3];
    logic        exp_ready;
    logic        exp_upd;
    acc_amp = '{16'h0003, 16'h00F0, 16'h0FFF};
    acc_lv  = '{5'd2, 5'd8, 5'd12};
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      exp_ready = ((k % 4) == 0);
      exp_upd   = ((k % 4) == 3);
      checks++;
      if (sec.i_ready !== exp_ready) begin
        errors++;
        $display("FAIL hs ready cyc%0d: got %b expected %b", k, sec.i_ready, exp_ready);
      end
      checks++;
      if (o_update !== exp_upd) begin
        errors++;
        $display("FAIL hs update cyc%0d: got %b expected %b", k, o_update, exp_upd);
      end
      if (k > 0 && (k % 4) == 0) begin
        checks++;
        if (o_level !== acc_lv[k/4-1] || o_peak !== acc_lv[k/4-1]) begin
          errors++;
          $display("FAIL hs result cyc%0d: got lvl %0d pk %0d expected %0d",
                   k, o_level, o_peak, acc_lv[k/4-1]);
        end
      end
      if (k < 12) begin
        // Non-accept cycles carry full-scale data that must be ignored.
        sec.i_valid     = 1'b1;
        sec.i_min_value = 16'h0000;
        sec.i_max_value = ((k % 4) == 0) ? acc_amp[k/4] : 16'hFFFF;
        @(negedge clk);
      end else begin
        sec.i_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int upd_cnt;
    upd_cnt         = 0;
    sec.i_valid     = 1'b1;
    sec.i_min_value = 16'h0000;
    sec.i_max_value = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    sec.i_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (o_level !== 5'd0 || o_peak !== 5'd0 || o_update !== 1'b0 || sec.i_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_clear: got lvl %0d pk %0d upd %b rdy %b expected 0 0 0 1",
               o_level, o_peak, o_update, sec.i_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (o_update === 1'b1) upd_cnt++;
    end
    checks++;
    if (upd_cnt != 0) begin
      errors++;
      $display("FAIL mid_reset_update: got %0d pulses expected 0", upd_cnt);
    end
    checks++;
    if (o_level !== 5'd0 || o_peak !== 5'd0 || sec.i_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after: got lvl %0d pk %0d rdy %b expected 0 0 1",
               o_level, o_peak, sec.i_ready);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_inverted();
    test_level_mapping();
    test_decay_peak();
    test_handshake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
